sl_transmitter: RTL and testbench

Serial-line (SL) transmitter: sends one 8-, 16- or 32-bit word on the two-wire sl0/sl1 link, followed by a parity symbol and a stop symbol. It is the sending end of the SL receive path and sits on the bridge's outbound side. The bridge hands it a word and a mode over a valid/ready handshake, and it generates the line symbols with programmable pulse and gap widths.

---
 rtl/sl_pkg.sv | 50 +++++
 rtl/sl_bit_timer.sv | 27 ++
 rtl/sl_transmitter.sv | 136 +++++++++++++
 tb/tb_sl_transmitter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: shared definitions for the SL serial link (transmitter and receiver).
//   sl_mode_e      word-length mode as carried on tx_mode / rx_mode
//   sl_tx_state_e  transmitter FSM states
//   sl_word_len    mode -> data symbol count (8/16/32, 0 for the illegal mode)
//   sl_odd_parity  parity bit making data+parity carry an odd number of 1s
//   sl_sym         line levels {sl0,sl1} for one data/parity bit
package sl_pkg;

  typedef enum logic [1:0] {
    SL_MODE_8   = 2'd0,
    SL_MODE_16  = 2'd1,
    SL_MODE_32  = 2'd2,
    SL_MODE_BAD = 2'd3
  } sl_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_PAR_LO,
    ST_PAR_HI,
    ST_STOP_LO,
    ST_STOP_HI
  } sl_tx_state_e;

  function automatic logic [5:0] sl_word_len(input sl_mode_e mode);
    case (mode)
      SL_MODE_8:  return 6'd8;
      SL_MODE_16: return 6'd16;
      SL_MODE_32: return 6'd32;
      default:    return 6'd0;
    endcase
  endfunction

  // XNOR reduction: parity is 1 when the data holds an even number of 1s.
  function automatic logic sl_odd_parity(input logic [31:0] data, input sl_mode_e mode);
    case (mode)
      SL_MODE_8:  return ~^data[7:0];
      SL_MODE_16: return ~^data[15:0];
      SL_MODE_32: return ~^data;
      default:    return 1'b1;
    endcase
  endfunction

  // A 0 pulls sl0 low, a 1 pulls sl1 low.
  function automatic logic [1:0] sl_sym(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// sl_bit_timer: loadable down-counter timing one symbol phase (pulse or gap).
//   clk_i       clock
//   reset_i     synchronous active-high reset (count -> 0)
//   load_i      load load_val_i this cycle
//   load_val_i  phase length minus one
//   expired_o   count has reached zero (last cycle of the phase)
module sl_bit_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)             cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: sends one 8/16/32-bit word LSB first on the sl0/sl1 pair,
// followed by an odd-parity symbol and a stop symbol (both lines low).
// Each symbol is held for PULSE_CYCLES, then both lines idle high for GAP_CYCLES.
//   clk_i       clock
//   reset_i     synchronous active-high reset; abandons any frame in flight
//   tx_data_i   word to send, bits [N-1:0] used
//   tx_mode_i   0=8, 1=16, 2=32 bits, 3=illegal (err pulse, nothing sent)
//   tx_valid_i  send request, sampled while tx_ready_o=1
//   tx_ready_o  idle, able to accept
//   sl0_o/sl1_o line outputs, idle high
//   done_o      one-cycle pulse after the stop symbol's gap
//   err_o       one-cycle pulse after a request with the illegal mode
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] tx_data_i,
  input  logic [1:0]  tx_mode_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        sl0_o,
  output logic        sl1_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  sl_tx_state_e state_q;
  sl_mode_e     mode_q;
  logic [31:0]  data_q;      // shifted right so bit 0 is always the current bit
  logic         par_q;
  logic [5:0]   bit_cnt_q;
  logic         sl0_q, sl1_q, ready_q, done_q, err_q;

  logic         accept, req_bad, last_bit;
  logic         tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;

  assign req_bad  = tx_valid_i & ready_q & (sl_mode_e'(tx_mode_i) == SL_MODE_BAD);
  assign accept   = tx_valid_i & ready_q & (sl_mode_e'(tx_mode_i) != SL_MODE_BAD);
  assign last_bit = (bit_cnt_q == sl_word_len(mode_q) - 6'd1);

  // Timer reloads on every state entry: leaving a LO state starts a gap,
  // leaving IDLE or a HI state starts a pulse.
  assign tmr_load = accept | ((state_q != ST_IDLE) & tmr_expired);
  assign tmr_val  = (state_q inside {ST_DATA_LO, ST_PAR_LO, ST_STOP_LO}) ? GAP_LD : PULSE_LD;

  sl_bit_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= SL_MODE_8;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      sl0_q     <= 1'b1;
      sl1_q     <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= req_bad;
      case (state_q)
        ST_IDLE: if (accept) begin
          data_q         <= tx_data_i;
          mode_q         <= sl_mode_e'(tx_mode_i);
          par_q          <= sl_odd_parity(tx_data_i, sl_mode_e'(tx_mode_i));
          bit_cnt_q      <= '0;
          {sl0_q, sl1_q} <= sl_sym(tx_data_i[0]);
          ready_q        <= 1'b0;
          state_q        <= ST_DATA_LO;
        end
        ST_DATA_LO: if (tmr_expired) begin
          {sl0_q, sl1_q} <= 2'b11;
          state_q        <= ST_DATA_HI;
        end
        ST_DATA_HI: if (tmr_expired) begin
          if (!last_bit) begin
            bit_cnt_q      <= bit_cnt_q + 6'd1;
            data_q         <= data_q >> 1;
            {sl0_q, sl1_q} <= sl_sym(data_q[1]);
            state_q        <= ST_DATA_LO;
          end else begin
            {sl0_q, sl1_q} <= sl_sym(par_q);
            state_q        <= ST_PAR_LO;
          end
        end
        ST_PAR_LO: if (tmr_expired) begin
          {sl0_q, sl1_q} <= 2'b11;
          state_q        <= ST_PAR_HI;
        end
        ST_PAR_HI: if (tmr_expired) begin
          {sl0_q, sl1_q} <= 2'b00;
          state_q        <= ST_STOP_LO;
        end
        ST_STOP_LO: if (tmr_expired) begin
          {sl0_q, sl1_q} <= 2'b11;
          state_q        <= ST_STOP_HI;
        end
        ST_STOP_HI: if (tmr_expired) begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          {sl0_q, sl1_q} <= 2'b11;
          ready_q        <= 1'b1;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o = ready_q;
  assign sl0_o      = sl0_q;
  assign sl1_o      = sl1_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter with PULSE_CYCLES=GAP_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_sl_transmitter;

  localparam int P = 4;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tx_data;
  logic [1:0]  tx_mode;
  logic        tx_valid;
  logic        tx_ready, sl0, sl1, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sl_transmitter #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .tx_data_i  (tx_data),
    .tx_mode_i  (tx_mode),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .sl0_o      (sl0),
    .sl1_o      (sl1),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the DUT idle. Requests word d, then at
  // cycle 1 applies (nv, nd, nm) to the inputs and checks every cycle of the
  // frame. Returns at the falling edge of cycle F+1 (done cycle).
  task automatic send_frame(input logic [31:0] d, input logic [1:0] m, input int n,
                            input logic par, input logic nv, input logic [31:0] nd,
                            input logic [1:0] nm);
    logic [1:0] exp_l;
    chk("ready_before_accept", tx_ready, 1);
    tx_valid = 1'b1; tx_data = d; tx_mode = m;
    @(negedge clk);
    tx_valid = nv; tx_data = nd; tx_mode = nm;
    for (int s = 0; s < n + 2; s++) begin
      if (s < n)       exp_l = d[s] ? 2'b10 : 2'b01;
      else if (s == n) exp_l = par  ? 2'b10 : 2'b01;
      else             exp_l = 2'b00;
      for (int c = 0; c < P + G; c++) begin
        chk($sformatf("d%0h_sym%0d_cyc%0d_lines", d, s, c), {sl0, sl1}, (c < P) ? exp_l : 2'b11);
        chk($sformatf("d%0h_sym%0d_cyc%0d_rdy_done_err", d, s, c), {tx_ready, done, err}, 3'b000);
        @(negedge clk);
      end
    end
    chk($sformatf("d%0h_done_cycle", d), {tx_ready, done, err, sl0, sl1}, 5'b11011);
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {tx_ready, done, err, sl0, sl1}, 5'b10011);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {tx_ready, done, err, sl0, sl1}, 5'b10011);

    // Mode 0, 0xA5: four 1s -> parity 1. Inputs scrambled mid-frame.
    send_frame(32'h0000_00A5, 2'd0, 8, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd2);
    @(negedge clk);
    chk("done_one_shot", {tx_ready, done, err, sl0, sl1}, 5'b10011);

    // Mode 1, upper half ignored: low 16 bits zero -> parity 1.
    send_frame(32'h1234_0000, 2'd1, 16, 1'b1, 1'b0, 32'h0000_FFFF, 2'd0);
    @(negedge clk);

    // Mode 2, 0x1: single 1 -> parity 0. F = 34*8 = 272.
    send_frame(32'h0000_0001, 2'd2, 32, 1'b0, 1'b0, 32'hAAAA_AAAA, 2'd1);
    @(negedge clk);

    // Illegal mode: err pulse, nothing sent.
    tx_valid = 1'b1; tx_mode = 2'd3; tx_data = 32'h0000_00A5;
    @(negedge clk);
    chk("bad_mode_err", {tx_ready, done, err, sl0, sl1}, 5'b10111);
    tx_valid = 1'b0; tx_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bad_mode_quiet_%0d", i), {tx_ready, done, err, sl0, sl1}, 5'b10011);
    end

    // Back-to-back with tx_valid held: second word loaded mid-frame is only
    // taken after the first frame's done cycle.
    send_frame(32'h0000_000F, 2'd0, 8, 1'b1, 1'b1, 32'h0000_00F0, 2'd0);
    send_frame(32'h0000_00F0, 2'd0, 8, 1'b1, 1'b0, 32'h0000_0000, 2'd1);
    @(negedge clk);
    chk("b2b_idle", {tx_ready, done, err, sl0, sl1}, 5'b10011);

    // Reset during the 5th data symbol (bit 4 = 1) of a mode-2 frame.
    tx_valid = 1'b1; tx_data = 32'h0000_0010; tx_mode = 2'd2;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (33) @(negedge clk);
    chk("sym4_before_reset", {tx_ready, sl0, sl1}, 3'b010);
    reset = 1'b1;
    @(negedge clk);
    chk("after_midframe_reset", {tx_ready, done, err, sl0, sl1}, 5'b10011);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk($sformatf("no_resume_%0d", i), {tx_ready, done, sl0, sl1}, 4'b1011);
    end
    // 0x3C: four 1s -> parity 1.
    send_frame(32'h0000_003C, 2'd0, 8, 1'b1, 1'b0, 32'h0000_0000, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
